// File: rtl/lif_array_if.sv
// Frame-in / results-out handshake bundle for the LIF neuron array.
interface lif_array_if #(
    parameter int N  = 4,
    parameter int T  = 4,
    parameter int Q  = 8,
    parameter int P  = 10,
    parameter int CW = $clog2(T + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [N*T*Q-1:0]  in_data;
    logic [Q-1:0]      threshold;
    logic [3:0]        cfg_leak_shift;
    logic              cfg_sub_reset;
    logic              cfg_persist;
    logic              out_valid;
    logic              out_ready;
    logic [N*T-1:0]    spike_out;
    logic [N*CW-1:0]   spike_cnt;
    logic [N*P-1:0]    potential_out;

    modport master (
        output in_valid, in_data, threshold, cfg_leak_shift, cfg_sub_reset, cfg_persist,
        output out_ready,
        input  in_ready, out_valid, spike_out, spike_cnt, potential_out
    );

    modport slave (
        input  in_valid, in_data, threshold, cfg_leak_shift, cfg_sub_reset, cfg_persist,
        input  out_ready,
        output in_ready, out_valid, spike_out, spike_cnt, potential_out
    );
endinterface

// File: rtl/lif_array.sv
// N-channel leaky integrate-and-fire array: one frame of T timesteps in,
// spike train, spike counts and final membrane potentials out.
module lif_array #(
    parameter int N  = 4,
    parameter int T  = 4,
    parameter int Q  = 8,
    parameter int P  = 10,
    parameter int CW = $clog2(T + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    lif_array_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int         TW   = (T > 1) ? $clog2(T) : 1;

    logic [1:0]          state;
    logic [TW-1:0]       t_idx;
    logic [N*T*Q-1:0]    data_r;
    logic [Q-1:0]        thr_r;
    logic [3:0]          shift_r;
    logic                sub_r;

    logic signed [P-1:0] v       [N];
    logic signed [P-1:0] v_next  [N];
    logic signed [Q-1:0] x_c     [N];
    logic signed [P-1:0] leak_c  [N];
    logic signed [P:0]   s_wide  [N];
    logic signed [P-1:0] s_c     [N];
    logic [N-1:0]        spk;
    logic signed [P-1:0] thr_ext;

    logic [N*T-1:0]      spike_r, spike_nxt;
    logic [N*CW-1:0]     cnt_r, cnt_nxt;
    logic [N*P-1:0]      pot_r;

    // Clamp a P+1 bit sum into the P bit signed potential range.
    function automatic logic signed [P-1:0] sat(input logic signed [P:0] x);
        if (x[P] != x[P-1])
            return x[P] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
        return x[P-1:0];
    endfunction

    function automatic logic signed [P-1:0] leak_of(input logic signed [P-1:0] val,
                                                    input logic [3:0] sh);
        return (sh == 4'd0) ? '0 : (val >>> sh);
    endfunction

    assign thr_ext = $signed({{(P-Q){1'b0}}, thr_r});

    always_comb begin
        spike_nxt = spike_r;
        cnt_nxt   = cnt_r;
        for (int c = 0; c < N; c++) begin
            x_c[c]    = $signed(data_r[(c*T + int'(t_idx))*Q +: Q]);
            leak_c[c] = leak_of(v[c], shift_r);
            s_wide[c] = $signed({v[c][P-1], v[c]})
                      - $signed({leak_c[c][P-1], leak_c[c]})
                      + $signed({{(P+1-Q){x_c[c][Q-1]}}, x_c[c]});
            s_c[c]    = sat(s_wide[c]);
            spk[c]    = (s_c[c] > thr_ext);
            if (!spk[c])
                v_next[c] = s_c[c];
            else if (sub_r)
                v_next[c] = s_c[c] - thr_ext;
            else
                v_next[c] = '0;
            spike_nxt[c*T + int'(t_idx)] = spk[c];
            cnt_nxt[c*CW +: CW] = cnt_r[c*CW +: CW] + {{(CW-1){1'b0}}, spk[c]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            t_idx   <= '0;
            data_r  <= '0;
            thr_r   <= '0;
            shift_r <= '0;
            sub_r   <= 1'b0;
            spike_r <= '0;
            cnt_r   <= '0;
            pot_r   <= '0;
            for (int c = 0; c < N; c++) v[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_r  <= bus.in_data;
                        thr_r   <= bus.threshold;
                        shift_r <= bus.cfg_leak_shift;
                        sub_r   <= bus.cfg_sub_reset;
                        spike_r <= '0;
                        cnt_r   <= '0;
                        t_idx   <= '0;
                        if (!bus.cfg_persist)
                            for (int c = 0; c < N; c++) v[c] <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    for (int c = 0; c < N; c++) v[c] <= v_next[c];
                    spike_r <= spike_nxt;
                    cnt_r   <= cnt_nxt;
                    if (t_idx == TW'(T-1)) begin
                        for (int c = 0; c < N; c++) pot_r[c*P +: P] <= v_next[c];
                        state <= DONE;
                    end else begin
                        t_idx <= t_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.spike_out     = spike_r;
    assign bus.spike_cnt     = cnt_r;
    assign bus.potential_out = pot_r;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: hand-computed frames, saturation, backpressure, reset.
module tb_lif_array;
    localparam int N  = 4;
    localparam int T  = 4;
    localparam int Q  = 8;
    localparam int P  = 10;
    localparam int CW = $clog2(T + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lif_array_if #(.N(N), .T(T), .Q(Q), .P(P), .CW(CW)) bus();

    lif_array #(.N(N), .T(T), .Q(Q), .P(P), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*T*Q-1:0] ch_data(input int c, input int x0, input int x1,
                                                 input int x2, input int x3);
        logic [N*T*Q-1:0] d;
        int xs[4];
        xs = '{x0, x1, x2, x3};
        d = '0;
        for (int t = 0; t < T; t++) d[(c*T + t)*Q +: Q] = xs[t][Q-1:0];
        return d;
    endfunction

    function automatic logic [N*P-1:0] pot4(input int p0, input int p1, input int p2, input int p3);
        logic [N*P-1:0] r;
        r = '0;
        r[0*P +: P] = p0[P-1:0];
        r[1*P +: P] = p1[P-1:0];
        r[2*P +: P] = p2[P-1:0];
        r[3*P +: P] = p3[P-1:0];
        return r;
    endfunction

    function automatic logic [N*CW-1:0] cnt4(input int c0, input int c1, input int c2, input int c3);
        logic [N*CW-1:0] r;
        r = '0;
        r[0*CW +: CW] = c0[CW-1:0];
        r[1*CW +: CW] = c1[CW-1:0];
        r[2*CW +: CW] = c2[CW-1:0];
        r[3*CW +: CW] = c3[CW-1:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N*T*Q-1:0] d, input int thr, input int sh,
                         input logic sub, input logic persist);
        bus.in_data        = d;
        bus.threshold      = thr[Q-1:0];
        bus.cfg_leak_shift = sh[3:0];
        bus.cfg_sub_reset  = sub;
        bus.cfg_persist    = persist;
    endtask

    // Handshake at edge A, then out_valid must be low through A+T-1 and high after A+T.
    task automatic run_frame(input string tag);
        bus.in_valid = 1'b1;
        check({tag, "_in_ready_pre"}, bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check({tag, "_in_ready_calc"}, bus.in_ready, 1'b0);
        repeat (T-1) step();
        check({tag, "_out_valid_early"}, bus.out_valid, 1'b0);
        step();
        check({tag, "_out_valid"}, bus.out_valid, 1'b1);
    endtask

    task automatic expect_out(input string tag, input logic [N*T-1:0] s,
                              input logic [N*CW-1:0] c, input logic [N*P-1:0] p);
        check({tag, "_spikes"}, bus.spike_out, s);
        check({tag, "_cnt"}, bus.spike_cnt, c);
        check({tag, "_pot"}, bus.potential_out, p);
    endtask

    task automatic take_out(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
        check({tag, "_out_valid_after"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive('0, 0, 0, 1'b0, 1'b0);
        #12;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        expect_out("rst", '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ch0 70 x4, thr 100, reset to zero
        drive(ch_data(0, 70, 70, 70, 70), 100, 0, 1'b0, 1'b0);
        run_frame("zero_reset");
        expect_out("zero_reset", 16'h000A, cnt4(2, 0, 0, 0), pot4(0, 0, 0, 0));
        take_out("zero_reset");

        // same stimulus, subtract threshold: 70,40,10,80
        drive(ch_data(0, 70, 70, 70, 70), 100, 0, 1'b1, 1'b0);
        run_frame("sub_reset");
        expect_out("sub_reset", 16'h0006, cnt4(2, 0, 0, 0), pot4(80, 0, 0, 0));
        take_out("sub_reset");

        // ch1 40 x4, thr 60, leak shift 1: 40,60,0,40
        drive(ch_data(1, 40, 40, 40, 40), 60, 1, 1'b0, 1'b0);
        run_frame("leak");
        expect_out("leak", 16'h0040, cnt4(0, 1, 0, 0), pot4(0, 40, 0, 0));
        take_out("leak");

        drive(ch_data(1, 40, 40, 40, 40), 60, 0, 1'b0, 1'b0);
        run_frame("noleak");
        expect_out("noleak", 16'h00A0, cnt4(0, 2, 0, 0), pot4(0, 0, 0, 0));
        take_out("noleak");

        // threshold 0 fires on s=1 only: 0,0,-1,-1
        drive(ch_data(0, 1, 0, -1, 0), 0, 0, 1'b0, 1'b0);
        run_frame("thr0");
        expect_out("thr0", 16'h0001, cnt4(1, 0, 0, 0), pot4(-1, 0, 0, 0));
        take_out("thr0");

        // saturation at -512, then persisted into the next frame
        drive(ch_data(2, -128, -128, -128, -128), 0, 0, 1'b0, 1'b0);
        run_frame("sat1");
        expect_out("sat1", 16'h0000, cnt4(0, 0, 0, 0), pot4(0, 0, -512, 0));
        take_out("sat1");

        drive(ch_data(2, -128, -128, 100, 0), 0, 0, 1'b0, 1'b1);
        run_frame("sat2");
        expect_out("sat2", 16'h0000, cnt4(0, 0, 0, 0), pot4(0, 0, -412, 0));
        take_out("sat2");
        repeat (3) step();
        check("idle_hold_pot", bus.potential_out, pot4(0, 0, -412, 0));

        // backpressure with a competing frame offered the whole time
        drive(ch_data(0, 70, 70, 70, 70), 100, 0, 1'b1, 1'b0);
        run_frame("bp");
        drive(ch_data(1, 40, 40, 40, 40), 60, 1, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            expect_out("bp_hold", 16'h0006, cnt4(2, 0, 0, 0), pot4(80, 0, 0, 0));
        end
        take_out("bp");
        step();
        bus.in_valid = 1'b0;
        check("bp_next_in_ready", bus.in_ready, 1'b0);
        repeat (T-1) step();
        check("bp_next_out_valid_early", bus.out_valid, 1'b0);
        step();
        check("bp_next_out_valid", bus.out_valid, 1'b1);
        expect_out("bp_next", 16'h0040, cnt4(0, 1, 0, 0), pot4(0, 40, 0, 0));
        take_out("bp_next");

        // asynchronous reset while t=2 is being processed
        drive(ch_data(3, 30, 30, 30, 30), 127, 0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        expect_out("arst", '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(ch_data(3, 30, 30, 30, 30), 127, 0, 1'b0, 1'b1);
        run_frame("post_rst");
        expect_out("post_rst", 16'h0000, cnt4(0, 0, 0, 0), pot4(0, 0, 0, 120));
        take_out("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
